spi_regfile_periph: RTL and testbench

SPI_REGFILE_PERIPH -- requirements
Module: spi_regfile_periph

---
 rtl/spi_regfile_periph.sv | 225 ++++++++++++++++++++++
 tb/tb_spi_regfile_periph.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_periph.sv
// spi_regfile_periph
//   SPI mode-0 target that exposes a small register file. A frame is a R/W bit
//   (1 = write), then the address MSB-first, then the data MSB-first. Writes
//   commit once the full frame has been shifted in. Reads return the addressed
//   register on CIPO during the data phase.
//
// Ports
//   clk        system clock (at least 8x SCLK)
//   rst_n      asynchronous active-low reset
//   SCLK/COPI/nCS  SPI pins, asynchronous to clk
//   CIPO       serial read data, MSB first, 0 while cipo_oe is low
//   cipo_oe    CIPO drive enable, high from read capture until nCS rises
//   regs_flat  register contents, register i at [i*DATA_W +: DATA_W]
//   wr_strobe  one-cycle pulse when a register write commits
//   wr_addr    address of the committed write
//   frame_err  one-cycle pulse at nCS rise when the frame length was wrong
module spi_regfile_periph #(
  parameter int SYNC_FLOPS = 2,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int NUM_REGS   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         SCLK,
  input  logic                         COPI,
  input  logic                         nCS,
  output logic                         CIPO,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);

  localparam logic [CNT_W-1:0] CNT_ADDR_END = CNT_W'(ADDR_W);        // count before last address sample
  localparam logic [CNT_W-1:0] CNT_DATA_END = CNT_W'(FRAME_LEN - 1); // count before last data sample
  localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(FRAME_LEN + 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CMD  = 3'd1;
  localparam logic [2:0] ADDR = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(NUM_REGS));
  endfunction

  logic [SYNC_FLOPS-1:0]        sclk_sync_r, copi_sync_r, ncs_sync_r;
  logic                         sclk_d_r, ncs_d_r;
  logic                         sclk_s, copi_s, ncs_s;
  logic                         sclk_rise_s, sclk_fall_s, ncs_rise_s, ncs_fall_s;
  logic                         sample_s, capture_s, commit_s;
  logic [2:0]                   state_r;
  logic [CNT_W-1:0]             cnt_r;
  logic [FRAME_LEN-1:0]         rx_r, rx_next_s;
  logic                         commit_pend_r;
  logic [ADDR_W-1:0]            commit_addr_r;
  logic [DATA_W-1:0]            commit_data_r;
  logic [NUM_REGS*DATA_W-1:0]   regs_r;
  logic [DATA_W-1:0]            rd_data_s;
  logic [DATA_W-1:0]            tx_r, tx_next_s;
  logic                         oe_r, oe_next_s, skip_r, skip_next_s;
  logic                         cipo_r, wr_strobe_r, frame_err_r;
  logic [ADDR_W-1:0]            wr_addr_r;

  assign sclk_s = sclk_sync_r[SYNC_FLOPS-1];
  assign copi_s = copi_sync_r[SYNC_FLOPS-1];
  assign ncs_s  = ncs_sync_r[SYNC_FLOPS-1];

  assign sclk_rise_s = ~sclk_d_r &  sclk_s;
  assign sclk_fall_s =  sclk_d_r & ~sclk_s;
  assign ncs_rise_s  = ~ncs_d_r  &  ncs_s;
  assign ncs_fall_s  =  ncs_d_r  & ~ncs_s;

  // Bits are only accepted inside a frame that started with a seen nCS fall.
  assign sample_s  = sclk_rise_s & ~ncs_s & ~ncs_fall_s & (state_r != IDLE);
  assign rx_next_s = {rx_r[FRAME_LEN-2:0], copi_s};
  // On the last address sample the R/W bit sits just above the address.
  assign capture_s = sample_s & (state_r == ADDR) & (cnt_r == CNT_ADDR_END) & ~rx_next_s[ADDR_W];
  assign commit_s  = sample_s & (state_r == DATA) & (cnt_r == CNT_DATA_END) & rx_next_s[FRAME_LEN-1]
                   & addr_valid(rx_next_s[FRAME_LEN-2 -: ADDR_W]);

  assign CIPO      = cipo_r;
  assign cipo_oe   = oe_r;
  assign regs_flat = regs_r;
  assign wr_strobe = wr_strobe_r;
  assign wr_addr   = wr_addr_r;
  assign frame_err = frame_err_r;

  // Input synchronizers plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= '0;
      copi_sync_r <= '0;
      ncs_sync_r  <= '0;
      sclk_d_r    <= 1'b0;
      ncs_d_r     <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_FLOPS-2:0], SCLK};
      copi_sync_r <= {copi_sync_r[SYNC_FLOPS-2:0], COPI};
      ncs_sync_r  <= {ncs_sync_r[SYNC_FLOPS-2:0], nCS};
      sclk_d_r    <= sclk_s;
      ncs_d_r     <= ncs_s;
    end
  end

  // Frame FSM, saturating bit counter and receive shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      rx_r    <= '0;
    end else if (ncs_fall_s) begin
      state_r <= CMD;
      cnt_r   <= '0;
      rx_r    <= '0;
    end else if (ncs_rise_s) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      rx_r    <= '0;
    end else if (sample_s) begin
      cnt_r <= (cnt_r == CNT_SAT) ? cnt_r : cnt_r + CNT_W'(1);
      // Bits past the end of the frame are dropped.
      rx_r  <= (cnt_r < CNT_FULL) ? rx_next_s : rx_r;
      case (state_r)
        CMD:     state_r <= ADDR;
        ADDR:    state_r <= (cnt_r == CNT_ADDR_END) ? DATA : ADDR;
        DATA:    state_r <= (cnt_r == CNT_DATA_END) ? DONE : DATA;
        default: state_r <= state_r;
      endcase
    end
  end

  // Write commit one clk after the final data sample; register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_pend_r <= 1'b0;
      commit_addr_r <= '0;
      commit_data_r <= '0;
      regs_r        <= '0;
      wr_strobe_r   <= 1'b0;
      wr_addr_r     <= '0;
    end else begin
      commit_pend_r <= commit_s;
      if (commit_s) begin
        commit_addr_r <= rx_next_s[FRAME_LEN-2 -: ADDR_W];
        commit_data_r <= rx_next_s[DATA_W-1:0];
      end
      wr_strobe_r <= commit_pend_r;
      if (commit_pend_r) begin
        wr_addr_r <= commit_addr_r;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit_pend_r && (commit_addr_r == ADDR_W'(i))) begin
          regs_r[i*DATA_W +: DATA_W] <= commit_data_r;
        end
      end
    end
  end

  // Read mux; an out-of-range address matches nothing and yields zero.
  always_comb begin
    rd_data_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_data_s = rd_data_s | ((rx_next_s[ADDR_W-1:0] == ADDR_W'(i)) ? regs_r[i*DATA_W +: DATA_W] : '0);
    end
  end

  // Transmit path. The MSB is driven at capture; the SCLK fall that closes the
  // last address bit is skipped so the host samples the MSB on the first data
  // rising edge, and every later fall advances one bit.
  always_comb begin
    tx_next_s   = tx_r;
    oe_next_s   = oe_r;
    skip_next_s = skip_r;
    if (ncs_rise_s || ncs_fall_s) begin
      tx_next_s   = '0;
      oe_next_s   = 1'b0;
      skip_next_s = 1'b0;
    end else if (capture_s) begin
      tx_next_s   = rd_data_s;
      oe_next_s   = 1'b1;
      skip_next_s = 1'b1;
    end else if (sclk_fall_s && oe_r) begin
      if (skip_r) begin
        skip_next_s = 1'b0;
      end else begin
        tx_next_s = tx_r << 1;
      end
    end else begin
      tx_next_s = tx_r;
    end
  end

  // Transmit registers and registered CIPO/cipo_oe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_r   <= '0;
      oe_r   <= 1'b0;
      skip_r <= 1'b0;
      cipo_r <= 1'b0;
    end else begin
      tx_r   <= tx_next_s;
      oe_r   <= oe_next_s;
      skip_r <= skip_next_s;
      cipo_r <= oe_next_s & tx_next_s[DATA_W-1];
    end
  end

  // Length check at the end of any frame that was actually started.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= ncs_rise_s & (state_r != IDLE) & (cnt_r != CNT_FULL);
    end
  end

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Directed bench for spi_regfile_periph: one instance with default parameters
// and one with ADDR_W=4, DATA_W=16, NUM_REGS=16, SYNC_FLOPS=3. Both share
// SCLK/COPI; each has its own nCS.
module tb_spi_regfile_periph;

  logic         clk = 1'b0;
  logic         rst_n, sclk, copi, ncs0, ncs1;
  logic         cipo0, oe0, wrs0, ferr0;
  logic         cipo1, oe1, wrs1, ferr1;
  logic [63:0]  regs0;
  logic [255:0] regs1;
  logic [6:0]   wra0;
  logic [3:0]   wra1;

  int nvec = 0;
  int nmis = 0;
  int wrs_cnt0 = 0, ferr_cnt0 = 0, wrs_cnt1 = 0, ferr_cnt1 = 0;
  logic [6:0] last_wra0 = 7'd0;
  logic [3:0] last_wra1 = 4'd0;
  logic [31:0] cipo_v, oe_v;
  int s0, f0, s1, f1;

  always #5 clk = ~clk;

  spi_regfile_periph dut0 (
    .clk(clk), .rst_n(rst_n), .SCLK(sclk), .COPI(copi), .nCS(ncs0),
    .CIPO(cipo0), .cipo_oe(oe0), .regs_flat(regs0),
    .wr_strobe(wrs0), .wr_addr(wra0), .frame_err(ferr0)
  );

  spi_regfile_periph #(.SYNC_FLOPS(3), .ADDR_W(4), .DATA_W(16), .NUM_REGS(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .SCLK(sclk), .COPI(copi), .nCS(ncs1),
    .CIPO(cipo1), .cipo_oe(oe1), .regs_flat(regs1),
    .wr_strobe(wrs1), .wr_addr(wra1), .frame_err(ferr1)
  );

  // Pulse monitors, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (wrs0) begin wrs_cnt0++; last_wra0 = wra0; end
    if (ferr0) ferr_cnt0++;
    if (wrs1) begin wrs_cnt1++; last_wra1 = wra1; end
    if (ferr1) ferr_cnt1++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Clock n bits out MSB-first; record CIPO/cipo_oe just before each rise.
  task automatic spi_bits(input int tgt, input int n, input logic [31:0] b);
    cipo_v = 32'd0;
    oe_v   = 32'd0;
    for (int i = 0; i < n; i++) begin
      copi = b[n-1-i];
      #80;
      cipo_v[n-1-i] = (tgt == 0) ? cipo0 : cipo1;
      oe_v[n-1-i]   = (tgt == 0) ? oe0 : oe1;
      sclk = 1'b1;
      #80;
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input int tgt, input int n, input logic [31:0] b);
    if (tgt == 0) ncs0 = 1'b0; else ncs1 = 1'b0;
    #200;
    spi_bits(tgt, n, b);
    #200;
    if (tgt == 0) ncs0 = 1'b1; else ncs1 = 1'b1;
    #400;
  endtask

  initial begin
    rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs0 = 1'b0; ncs1 = 1'b1;
    #50;
    chk("rst_regs", regs0, 64'h0);
    chk("rst_outs", {cipo0, oe0, wrs0, ferr0, 1'b0, wra0}, 12'h000);
    #50 rst_n = 1'b1;
    #100;

    // nCS low through reset release: bits must be ignored until a fresh fall.
    s0 = wrs_cnt0; f0 = ferr_cnt0;
    spi_bits(0, 16, 32'h81FF);
    #200 ncs0 = 1'b1;
    #400;
    chk("held_ncs_regs", regs0, 64'h0);
    chk("held_ncs_strobe", 64'(wrs_cnt0 - s0), 64'd0);
    chk("held_ncs_ferr", 64'(ferr_cnt0 - f0), 64'd0);

    // Basic write: reg 2 = 0xA5.
    s0 = wrs_cnt0; f0 = ferr_cnt0;
    frame(0, 16, 32'h82A5);
    chk("wr2_regs", regs0, 64'h0000_0000_00A5_0000);
    chk("wr2_strobe", 64'(wrs_cnt0 - s0), 64'd1);
    chk("wr2_addr", 64'(last_wra0), 64'd2);
    chk("wr2_ferr", 64'(ferr_cnt0 - f0), 64'd0);

    // Preload reg 4 = 0x3C, then read it back.
    frame(0, 16, 32'h843C);
    s0 = wrs_cnt0; f0 = ferr_cnt0;
    frame(0, 16, 32'h0400);
    chk("rd4_cipo", 64'(cipo_v[15:0]), 64'h003C);
    chk("rd4_oe", 64'(oe_v[15:0]), 64'h00FF);
    chk("rd4_after", {62'd0, cipo0, oe0}, 64'd0);
    chk("rd4_strobe", 64'(wrs_cnt0 - s0), 64'd0);
    chk("rd4_ferr", 64'(ferr_cnt0 - f0), 64'd0);

    // Out-of-range write and read.
    s0 = wrs_cnt0; f0 = ferr_cnt0;
    frame(0, 16, 32'h8977);
    chk("wr9_regs", regs0, 64'h0000_003C_00A5_0000);
    chk("wr9_strobe", 64'(wrs_cnt0 - s0), 64'd0);
    chk("wr9_ferr", 64'(ferr_cnt0 - f0), 64'd0);
    frame(0, 16, 32'h0900);
    chk("rd9_cipo", 64'(cipo_v[15:0]), 64'h0000);
    chk("rd9_oe", 64'(oe_v[15:0]), 64'h00FF);

    // Short (12-bit) write frame.
    s0 = wrs_cnt0; f0 = ferr_cnt0;
    frame(0, 12, 32'h081F);
    chk("short_regs", regs0, 64'h0000_003C_00A5_0000);
    chk("short_strobe", 64'(wrs_cnt0 - s0), 64'd0);
    chk("short_ferr", 64'(ferr_cnt0 - f0), 64'd1);

    // Long (18-bit) write frame: reg 3 = 0x5A, extra bits dropped.
    s0 = wrs_cnt0; f0 = ferr_cnt0;
    frame(0, 18, 32'h0002_0D6B);
    chk("long_regs", regs0, 64'h0000_003C_5AA5_0000);
    chk("long_strobe", 64'(wrs_cnt0 - s0), 64'd1);
    chk("long_addr", 64'(last_wra0), 64'd3);
    chk("long_ferr", 64'(ferr_cnt0 - f0), 64'd1);

    // Back-to-back frames separated by a one-clk nCS high pulse.
    s0 = wrs_cnt0; f0 = ferr_cnt0;
    ncs0 = 1'b0;
    #200;
    spi_bits(0, 16, 32'h87E7);
    #200 ncs0 = 1'b1;
    #10  ncs0 = 1'b0;
    #200;
    spi_bits(0, 16, 32'h8666);
    #200 ncs0 = 1'b1;
    #400;
    chk("b2b_regs", regs0, 64'hE766_003C_5AA5_0000);
    chk("b2b_strobe", 64'(wrs_cnt0 - s0), 64'd2);
    chk("b2b_addr", 64'(last_wra0), 64'd6);
    chk("b2b_ferr", 64'(ferr_cnt0 - f0), 64'd0);

    // Reset in the middle of a write frame, then a clean frame.
    s0 = wrs_cnt0;
    ncs0 = 1'b0;
    #200;
    spi_bits(0, 10, 32'h0214);
    rst_n = 1'b0;
    #50;
    chk("abort_regs", regs0, 64'h0);
    chk("abort_outs", {cipo0, oe0, wrs0, ferr0, 1'b0, wra0}, 12'h000);
    ncs0 = 1'b1;
    #100 rst_n = 1'b1;
    #400;
    chk("abort_strobe", 64'(wrs_cnt0 - s0), 64'd0);
    s0 = wrs_cnt0; f0 = ferr_cnt0;
    frame(0, 16, 32'h8511);
    chk("post_rst_regs", regs0, 64'h0000_1100_0000_0000);
    chk("post_rst_strobe", 64'(wrs_cnt0 - s0), 64'd1);
    chk("post_rst_addr", 64'(last_wra0), 64'd5);
    chk("post_rst_ferr", 64'(ferr_cnt0 - f0), 64'd0);

    // Wide configuration: 21-bit frames.
    s1 = wrs_cnt1; f1 = ferr_cnt1;
    frame(1, 21, 32'h0012_A5C3);
    chk("w_wr2_reg", 64'(regs1[47:32]), 64'hA5C3);
    chk("w_wr2_strobe", 64'(wrs_cnt1 - s1), 64'd1);
    chk("w_wr2_addr", 64'(last_wra1), 64'd2);
    chk("w_wr2_ferr", 64'(ferr_cnt1 - f1), 64'd0);
    frame(1, 21, 32'h0014_3C5A);
    chk("w_wr4_reg", 64'(regs1[79:64]), 64'h3C5A);
    s1 = wrs_cnt1; f1 = ferr_cnt1;
    frame(1, 21, 32'h0004_0000);
    chk("w_rd4_cipo", 64'(cipo_v[20:0]), 64'h00_3C5A);
    chk("w_rd4_oe", 64'(oe_v[20:0]), 64'h00_FFFF);
    chk("w_rd4_strobe", 64'(wrs_cnt1 - s1), 64'd0);
    chk("w_rd4_ferr", 64'(ferr_cnt1 - f1), 64'd0);
    chk("w_dut0_untouched", regs0, 64'h0000_1100_0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
